// File: rtl/alu_op_sequencer.sv
// Multi-cycle control sequencer for the register-file / A-B-C pipeline-register / ALU datapath.
// Takes one register-level command per valid/ready handshake and emits Moore-decoded datapath strobes.
module alu_op_sequencer #(
    parameter int RA_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [RA_W-1:0] cmd_rd,
    input  logic [RA_W-1:0] cmd_rn,
    input  logic [RA_W-1:0] cmd_rm,
    output logic [RA_W-1:0] readnum,
    output logic [RA_W-1:0] writenum,
    output logic            write,
    output logic            loada,
    output logic            loadb,
    output logic            loadc,
    output logic            loads,
    output logic            asel,
    output logic            vsel,
    output logic [1:0]      ALUop,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [2:0] OP_MOVI = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_CMP  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MVN  = 3'b101;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LA   = 3'd1,
        S_LB   = 3'd2,
        S_EX   = 3'd3,
        S_WB   = 3'd4,
        S_WIMM = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [RA_W-1:0] rd_q, rd_d;
    logic [RA_W-1:0] rn_q, rn_d;
    logic [RA_W-1:0] rm_q, rm_d;

    // First state after accept; MOV/MVN only need the B operand so they skip LA.
    function automatic state_t entry_state(input logic [2:0] op);
        case (op)
            OP_MOVI:                 return S_WIMM;
            OP_MOV, OP_MVN:          return S_LB;
            OP_ADD, OP_CMP, OP_AND:  return S_LA;
            default:                 return S_ERR;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rn_q    <= rn_d;
            rm_q    <= rm_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rn_d      = rn_q;
        rm_d      = rm_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        readnum   = '0;
        writenum  = '0;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        vsel      = 1'b0;
        ALUop     = ALU_ADD;
        done      = 1'b0;
        err       = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    rd_d    = cmd_rd;
                    rn_d    = cmd_rn;
                    rm_d    = cmd_rm;
                    state_d = entry_state(cmd_op);
                end
            end
            S_LA: begin
                readnum = rn_q;
                loada   = 1'b1;
                state_d = S_LB;
            end
            S_LB: begin
                readnum = rm_q;
                loadb   = 1'b1;
                state_d = S_EX;
            end
            S_EX: begin
                state_d = S_WB;
                loadc   = 1'b1;
                case (op_q)
                    OP_MOV: begin
                        asel  = 1'b1;
                        ALUop = ALU_ADD;
                    end
                    OP_MVN: ALUop = ALU_NOTB;
                    OP_AND: ALUop = ALU_AND;
                    // CMP only updates status and finishes here without a writeback.
                    OP_CMP: begin
                        ALUop   = ALU_SUB;
                        loadc   = 1'b0;
                        loads   = 1'b1;
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                    default: ALUop = ALU_ADD;
                endcase
            end
            S_WB: begin
                writenum = rd_q;
                write    = 1'b1;
                done     = 1'b1;
                state_d  = S_IDLE;
            end
            S_WIMM: begin
                vsel     = 1'b1;
                writenum = rd_q;
                write    = 1'b1;
                done     = 1'b1;
                state_d  = S_IDLE;
            end
            S_ERR: begin
                done    = 1'b1;
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a small behavioural register-file/ALU datapath.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_rd, cmd_rn, cmd_rm;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, loads, asel, vsel;
    logic [1:0]  ALUop;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    logic [15:0] R [8];
    logic [15:0] A, B, C, imm;
    logic        Z;

    string       tag_q [$];
    logic [18:0] exp_q [$];

    always #5 clk = ~clk;

    alu_op_sequencer #(.RA_W(3)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .vsel(vsel), .ALUop(ALUop),
        .busy(busy), .done(done), .err(err)
    );

    wire [18:0] obs = {cmd_ready, busy, done, err, write, loada, loadb, loadc, loads,
                       asel, vsel, ALUop, readnum, writenum};

    function automatic logic [15:0] alu(input logic [15:0] a, b, input logic as, input logic [1:0] op);
        logic [15:0] ain;
        ain = as ? 16'h0000 : a;
        case (op)
            2'b00:   return ain + b;
            2'b01:   return ain - b;
            2'b10:   return ain & b;
            default: return ~b;
        endcase
    endfunction

    // Behavioural datapath driven purely by the sequencer strobes
    always @(posedge clk) begin
        if (write === 1'b1) begin
            R[writenum] <= vsel ? imm : C;
            wr_cnt      <= wr_cnt + 1;
        end
        if (loada === 1'b1) A <= R[readnum];
        if (loadb === 1'b1) B <= R[readnum];
        if (loadc === 1'b1) C <= alu(A, B, asel, ALUop);
        if (loads === 1'b1) Z <= (alu(A, B, asel, ALUop) == 16'h0000);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] v(input logic rdy, bsy, dn, er, wr, la, lb, lc, ls, as, vs,
                                      input logic [1:0] aop, input logic [2:0] rn, wn);
        return {rdy, bsy, dn, er, wr, la, lb, lc, ls, as, vs, aop, rn, wn};
    endfunction

    localparam logic [18:0] IDLE_V = 19'b1_0000_0000_0000_000_000;

    task automatic push(input string tag, input logic [18:0] e);
        tag_q.push_back(tag);
        exp_q.push_back(e);
    endtask

    task automatic push_seq(input logic [2:0] op, rd, rn, rm);
        case (op)
            3'b000: push("wimm", v(0,1,1,0,1,0,0,0,0,0,1,2'b00,3'd0,rd));
            3'b001, 3'b101: begin
                push("lb", v(0,1,0,0,0,0,1,0,0,0,0,2'b00,rm,3'd0));
                if (op == 3'b001) push("ex_mov", v(0,1,0,0,0,0,0,1,0,1,0,2'b00,3'd0,3'd0));
                else              push("ex_mvn", v(0,1,0,0,0,0,0,1,0,0,0,2'b11,3'd0,3'd0));
                push("wb", v(0,1,1,0,1,0,0,0,0,0,0,2'b00,3'd0,rd));
            end
            3'b010, 3'b100: begin
                push("la", v(0,1,0,0,0,1,0,0,0,0,0,2'b00,rn,3'd0));
                push("lb", v(0,1,0,0,0,0,1,0,0,0,0,2'b00,rm,3'd0));
                if (op == 3'b010) push("ex_add", v(0,1,0,0,0,0,0,1,0,0,0,2'b00,3'd0,3'd0));
                else              push("ex_and", v(0,1,0,0,0,0,0,1,0,0,0,2'b10,3'd0,3'd0));
                push("wb", v(0,1,1,0,1,0,0,0,0,0,0,2'b00,3'd0,rd));
            end
            3'b011: begin
                push("la", v(0,1,0,0,0,1,0,0,0,0,0,2'b00,rn,3'd0));
                push("lb", v(0,1,0,0,0,0,1,0,0,0,0,2'b00,rm,3'd0));
                push("ex_cmp", v(0,1,1,0,0,0,0,0,1,0,0,2'b01,3'd0,3'd0));
            end
            default: push("err", v(0,1,1,1,0,0,0,0,0,0,0,2'b00,3'd0,3'd0));
        endcase
        push("idle_after", IDLE_V);
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            @(negedge clk);
            chk(tag_q.pop_front(), 32'(obs), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, rd, rn, rm);
        int waitc;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm;
        waitc = 0;
        while (cmd_ready !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (cmd_ready !== 1'b1) begin
            chk("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom_range(7, 0));
        cmd_rd = 3'($urandom_range(7, 0));
        cmd_rn = 3'($urandom_range(7, 0));
        cmd_rm = 3'($urandom_range(7, 0));
        push_seq(op, rd, rn, rm);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        for (int i = 0; i < 8; i++) R[i] = 16'h0000;
        A = '0; B = '0; C = '0; Z = 1'b0; imm = '0;
        reset = 1'b1; cmd_valid = 1'b0;
        cmd_op = '0; cmd_rd = '0; cmd_rn = '0; cmd_rm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_idle", 32'(obs), 32'(IDLE_V));
        end

        // Abort an ADD with reset while in LB
        w0 = wr_cnt;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'b010; cmd_rd = 3'd6; cmd_rn = 3'd0; cmd_rm = 3'd1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_la", 32'(obs), 32'(v(0,1,0,0,0,1,0,0,0,0,0,2'b00,3'd0,3'd0)));
        @(negedge clk);
        chk("abort_lb", 32'(obs), 32'(v(0,1,0,0,0,0,1,0,0,0,0,2'b00,3'd1,3'd0)));
        reset = 1'b1;
        @(negedge clk);
        chk("abort_idle", 32'(obs), 32'(IDLE_V));
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_idle_hold", 32'(obs), 32'(IDLE_V));
        chk("abort_nowrite", 32'(wr_cnt), 32'(w0));

        imm = 16'h1234; run_cmd(3'b000, 3'd3, 3'd0, 3'd0);
        chk("R3_movi", 32'(R[3]), 32'h1234);
        imm = 16'h0003;
        run_cmd(3'b000, 3'd0, 3'd0, 3'd0);
        run_cmd(3'b000, 3'd1, 3'd0, 3'd0);
        run_cmd(3'b000, 3'd4, 3'd0, 3'd0);
        run_cmd(3'b000, 3'd6, 3'd0, 3'd0);
        imm = 16'hDEAD;

        run_cmd(3'b010, 3'd2, 3'd0, 3'd1);
        chk("R2_add", 32'(R[2]), 32'h0006);

        w0 = wr_cnt;
        run_cmd(3'b011, 3'd0, 3'd4, 3'd4);
        chk("Z_cmp_eq", 32'(Z), 32'd1);
        chk("cmp_nowrite", 32'(wr_cnt), 32'(w0));

        run_cmd(3'b101, 3'd5, 3'd2, 3'd6);
        chk("R5_mvn", 32'(R[5]), 32'hFFFC);
        run_cmd(3'b001, 3'd7, 3'd2, 3'd6);
        chk("R7_mov", 32'(R[7]), 32'h0003);

        run_cmd(3'b100, 3'd1, 3'd2, 3'd0);
        chk("R1_and", 32'(R[1]), 32'h0002);
        run_cmd(3'b011, 3'd0, 3'd2, 3'd0);
        chk("Z_cmp_ne", 32'(Z), 32'd0);
        run_cmd(3'b010, 3'd4, 3'd4, 3'd4);
        chk("R4_alias", 32'(R[4]), 32'h0006);

        w0 = wr_cnt;
        run_cmd(3'b110, 3'd2, 3'd2, 3'd2);
        chk("illegal_nowrite", 32'(wr_cnt), 32'(w0));

        // Illegal op, then cmd_valid held through busy with a new command
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'b111; cmd_rd = 3'd3; cmd_rn = 3'd3; cmd_rm = 3'd3;
        @(posedge clk);
        #1;
        cmd_op = 3'b000; cmd_rd = 3'd1; imm = 16'h00A5;
        push("hold_err", v(0,1,1,1,0,0,0,0,0,0,0,2'b00,3'd0,3'd0));
        push("hold_idle", IDLE_V);
        drain();
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        push_seq(3'b000, 3'd1, 3'd0, 3'd0);
        drain();
        chk("R1_held_movi", 32'(R[1]), 32'h00A5);
        chk("R3_untouched", 32'(R[3]), 32'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
